// File: rtl/nonce_select.sv
// nonce_select: scans NUM_NONCES hash words in memory for the minimum (lowest index on ties),
// compares it with a difficulty target and writes a two-word result record back.
module nonce_select #(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        hash_addr,
    input  logic [15:0]        result_addr,
    input  logic [31:0]        target,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [31:0]        best_hash,
    output logic               mem_clk,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
);
    typedef enum logic [2:0] {IDLE, PRIME, SCAN, WR0, WR1, FIN} state_t;
    localparam logic [NONCE_W:0]   RC_END   = (NONCE_W+1)'(NUM_NONCES);
    localparam logic [NONCE_W-1:0] IDX_LAST = NONCE_W'(NUM_NONCES - 1);
    state_t             state, state_n;
    logic [15:0]        hash_base, hash_base_n, res_base, res_base_n, mem_addr_n;
    logic [31:0]        tgt, tgt_n, best_hash_n, mem_write_data_n;
    logic [NONCE_W-1:0] idx, idx_n, best_nonce_n;
    logic [NONCE_W:0]   rc, rc_n;
    logic               done_n, found_n, mem_we_n;
    assign mem_clk = clk;
    // Reads run two words ahead of the sample point: rc is the next word to address, idx the word arriving now.
    always_comb begin
        state_n          = state;
        hash_base_n      = hash_base;
        res_base_n       = res_base;
        tgt_n            = tgt;
        idx_n            = idx;
        rc_n             = rc;
        done_n           = done;
        found_n          = found;
        best_nonce_n     = best_nonce;
        best_hash_n      = best_hash;
        mem_we_n         = mem_we;
        mem_addr_n       = mem_addr;
        mem_write_data_n = mem_write_data;
        case (state)
            IDLE: if (start) begin
                hash_base_n = hash_addr;
                res_base_n  = result_addr;
                tgt_n       = target;
                mem_addr_n  = hash_addr;
                mem_we_n    = 1'b0;
                done_n      = 1'b0;
                found_n     = 1'b0;
                best_hash_n = '1;
                idx_n       = '0;
                rc_n        = (NONCE_W+1)'(1);
                state_n     = PRIME;
            end
            PRIME: begin
                mem_addr_n = hash_base + 16'(rc);
                rc_n       = rc + 1'b1;
                state_n    = SCAN;
            end
            SCAN: begin
                if (rc < RC_END) begin
                    mem_addr_n = hash_base + 16'(rc);
                    rc_n       = rc + 1'b1;
                end
                if (mem_read_data < best_hash) begin
                    best_hash_n  = mem_read_data;
                    best_nonce_n = idx;
                end
                idx_n = idx + 1'b1;
                if (idx == IDX_LAST) begin
                    found_n          = best_hash_n < tgt;
                    mem_we_n         = 1'b1;
                    mem_addr_n       = res_base;
                    mem_write_data_n = {found_n, {(31-NONCE_W){1'b0}}, best_nonce_n};
                    state_n          = WR0;
                end
            end
            WR0: begin
                mem_we_n         = 1'b1;
                mem_addr_n       = res_base + 16'd1;
                mem_write_data_n = best_hash;
                state_n          = WR1;
            end
            WR1: begin
                mem_we_n = 1'b0;
                done_n   = 1'b1;
                state_n  = FIN;
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hash_base      <= '0;
            res_base       <= '0;
            tgt            <= '0;
            idx            <= '0;
            rc             <= '0;
            done           <= 1'b0;
            found          <= 1'b0;
            best_nonce     <= '0;
            best_hash      <= '1;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            state          <= state_n;
            hash_base      <= hash_base_n;
            res_base       <= res_base_n;
            tgt            <= tgt_n;
            idx            <= idx_n;
            rc             <= rc_n;
            done           <= done_n;
            found          <= found_n;
            best_nonce     <= best_nonce_n;
            best_hash      <= best_hash_n;
            mem_we         <= mem_we_n;
            mem_addr       <= mem_addr_n;
            mem_write_data <= mem_write_data_n;
        end
    end
endmodule

// File: tb/tb_nonce_select.sv
// tb_nonce_select: directed scans against a memory model and a min-search reference model.
module tb_nonce_select;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] hash_addr, result_addr;
    logic [31:0] target;
    logic        done, found, mem_clk, mem_we;
    logic [4:0]  best_nonce;
    logic [31:0] best_hash, mem_write_data, mem_read_data;
    logic [15:0] mem_addr;
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    logic [31:0] img [16];
    logic        ld = 1'b0;
    logic [15:0] ld_base = '0, ld_rb = '0;
    int          wr_cnt = 0;
    int          checks = 0, errors = 0;
    logic [4:0]  exp_nonce = '0;
    logic [31:0] exp_hash = '1;
    logic        exp_found = 1'b0;
    logic [15:0] cur_res = '0;

    nonce_select #(.NUM_NONCES(16), .NONCE_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .hash_addr(hash_addr),
        .result_addr(result_addr), .target(target), .done(done), .found(found),
        .best_nonce(best_nonce), .best_hash(best_hash), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    assign mem_read_data = rd_q;

    // Memory: address registered at edge k yields data sampled at k+2.
    always @(posedge clk) begin
        rd_q <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_write_data;
            wr_cnt++;
        end
        if (ld) begin
            for (int i = 0; i < 16; i++) mem[16'(ld_base + 16'(i))] <= img[i];
            mem[ld_rb] <= 32'hDEADBEEF;
            mem[16'(ld_rb + 16'd1)] <= 32'hDEADBEEF;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] tg, output logic [4:0] bn,
                                  output logic [31:0] bh, output logic f);
        bh = '1;
        bn = '0;
        for (int i = 0; i < 16; i++)
            if (img[i] < bh) begin
                bh = img[i];
                bn = 5'(i);
            end
        f = bh < tg;
    endfunction

    task automatic load(input logic [15:0] ha, input logic [15:0] ra);
        @(negedge clk);
        ld_base = ha;
        ld_rb = ra;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg, input bit pulse);
        int n, w0;
        logic [4:0] mn;
        logic [31:0] mh;
        logic mf;
        @(negedge clk);
        model(tg, mn, mh, mf);
        w0 = wr_cnt;
        hash_addr = ha;
        result_addr = ra;
        target = tg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hash_addr = 16'h5A5A;
        result_addr = 16'hA5A5;
        target = 32'h0;
        chk("done_fall", 32'(done), 32'd0);
        exp_nonce = mn;
        exp_hash = mh;
        exp_found = mf;
        cur_res = ra;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            start = pulse && (n == 5 || n == 18);
        end
        start = 1'b0;
        chk("latency", 32'(n), 32'd19);
        chk("write_count", 32'(wr_cnt - w0), 32'd2);
        chk("rec_word0", mem[ra], {mf, 26'b0, mn});
        chk("rec_word1", mem[16'(ra + 16'd1)], mh);
    endtask

    // Held outputs must match the model whenever done is up; writes only ever hit the record.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                chk("best_nonce", 32'(best_nonce), 32'(exp_nonce));
                chk("best_hash", best_hash, exp_hash);
                chk("found", 32'(found), 32'(exp_found));
                chk("we_when_done", 32'(mem_we), 32'd0);
            end
            if (mem_we)
                chk("write_addr", 32'(mem_addr == cur_res || mem_addr == 16'(cur_res + 16'd1)), 32'd1);
        end
    end

    initial begin
        int w0;
        reset = 1'b1;
        start = 1'b0;
        hash_addr = '0;
        result_addr = '0;
        target = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_nonce", 32'(best_nonce), 32'd0);
        chk("rst_hash", best_hash, 32'hFFFFFFFF);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) img[i] = 32'hFFFFFFFF;
        load(16'h0000, 16'h0040);
        scan(16'h0000, 16'h0040, 32'h0, 1'b0);
        chk("ones_nonce", 32'(best_nonce), 32'd0);
        chk("ones_rec0", mem[16'h0040], 32'h0);

        for (int i = 0; i < 16; i++) img[i] = 32'(16 - i);
        load(16'h0100, 16'h0200);
        scan(16'h0100, 16'h0200, 32'd5, 1'b0);
        chk("desc_nonce", 32'(best_nonce), 32'd15);
        chk("desc_hash", best_hash, 32'd1);
        chk("desc_found", 32'(found), 32'd1);
        chk("desc_rec0", mem[16'h0200], 32'h8000000F);
        chk("desc_rec1", mem[16'h0201], 32'd1);

        for (int i = 0; i < 16; i++) img[i] = 32'h12345678;
        load(16'h0100, 16'h0200);
        scan(16'h0100, 16'h0200, 32'h12345678, 1'b0);
        chk("eq_found", 32'(found), 32'd0);
        chk("eq_nonce", 32'(best_nonce), 32'd0);
        chk("eq_rec0", mem[16'h0200], 32'h0);

        for (int i = 0; i < 16; i++) img[i] = 32'hFFFF0000;
        img[4] = 32'd3;
        img[9] = 32'd3;
        load(16'h0100, 16'h0200);
        scan(16'h0100, 16'h0200, 32'hFFFFFFFF, 1'b1);
        chk("tie_nonce", 32'(best_nonce), 32'd4);
        chk("tie_hash", best_hash, 32'd3);
        chk("tie_rec0", mem[16'h0200], 32'h80000004);

        for (int i = 0; i < 16; i++) img[i] = $urandom;
        load(16'h0300, 16'h0400);
        @(negedge clk);
        hash_addr = 16'h0300;
        result_addr = 16'h0400;
        target = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        w0 = wr_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_hash", best_hash, 32'hFFFFFFFF);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        repeat (25) @(negedge clk);
        chk("mid_rst_nowrite", 32'(wr_cnt - w0), 32'd0);
        chk("mid_rst_rec", mem[16'h0400], 32'hDEADBEEF);
        scan(16'h0300, 16'h0400, 32'h80000000, 1'b0);

        for (int i = 0; i < 16; i++) img[i] = $urandom;
        load(16'h1234, 16'hFFFF);
        scan(16'h1234, 16'hFFFF, 32'h40000000, 1'b0);

        for (int i = 0; i < 16; i++) img[i] = $urandom | 32'h00010000;
        img[11] = 32'h00000777;
        load(16'hFFF8, 16'h0500);
        scan(16'hFFF8, 16'h0500, 32'h00001000, 1'b0);
        chk("wrap_nonce", 32'(best_nonce), 32'd11);
        chk("wrap_rec1", mem[16'h0501], 32'h00000777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
